// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
// Holds the FSM state encoding, the default operand width and the counter-width helper.
package serial_add_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Bit-counter width: $clog2 of the width, never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// One-bit full-adder cell `fa`, time-shared by serial_add_ctrl across all bit positions.
module fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one fa cell adds WIDTH-bit operands LSB first, one bit per clock.
// Build option SERIAL_ADD_OVF_EN adds the signed-overflow output ovf.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int               CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_sh_q, res_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [WIDTH-1:0] res_shift;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             fa_sum, fa_cout;
   logic             last_bit;

   fa u_fa (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   assign last_bit = (cnt_q == LAST);

   // Result shifter: the new bit enters at the MSB so that after WIDTH bits it lands in place.
   if (WIDTH == 1) begin : g_res_w1
      assign res_shift = fa_sum;
   end else begin : g_res_wn
      assign res_shift = {fa_sum, res_sh_q[WIDTH-1:1]};
   end

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT:   if (last_bit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         SHIFT: busy = 1'b1;
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_sh_d = res_sh_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d   = a;
               b_sh_d   = b;
               carry_d  = cin;
               res_sh_d = '0;
               cnt_d    = '0;
            end
         end
         SHIFT: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            res_sh_d = res_shift;
            carry_d  = fa_cout;
            cnt_d    = cnt_q + 1'b1;
            if (last_bit) begin
               sum_d  = res_shift;
               cout_d = fa_cout;
            end
         end
         default: ;
      endcase
   end

   // NOTE: the shift registers are plain flops, so they are reset along with everything else.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
      end else begin
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_sh_q <= res_sh_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

`ifdef SERIAL_ADD_OVF_EN
   // On the last bit, carry_q is the carry into the MSB.
   logic ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q;
      if (state_q == SHIFT && last_bit) begin
         ovf_d = carry_q ^ fa_cout;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule
